xor_cipher_seq: RTL and testbench

- Frame sequencer for the XOR cipher keystream datapath.
- Holds the keystream seed, loaded serially from pins.
- On start: loads the seed into the external keystream generator, then steps it once per accepted data bit over a valid/ready stream, emitting in_bit XOR ks_bit.
- Counts a programmable frame length and reports completion; sits between the chip I/O pins and the keystream LFSR / XOR core.

---
 rtl/xor_cipher_seq.sv | 104 ++++++++++
 tb/tb_xor_cipher_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_cipher_seq.sv
// Frame sequencer: serial seed load, keystream generator load/step, in_bit ^ ks_bit stream, frame counting.
// Latency: one cycle from input accept to out_valid. Backpressure: in_ready drops while an unaccepted output is held.
module xor_cipher_seq #(
  parameter int                SEED_W       = 16,
  parameter logic [SEED_W-1:0] SEED_DEFAULT = 16'hACE1,
  parameter int                LEN_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_bit,
  input  logic              seed_shift,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_bit,
  input  logic              out_ready,
  output logic [SEED_W-1:0] ks_seed,
  output logic              ks_load,
  output logic              ks_step,
  input  logic              ks_bit,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  remaining
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SEED_W-1:0] seed_reg;
  logic              drain_ok;
  logic              accept;
  logic              abort_hit;

  // The output slot is free when empty or being handed off this cycle.
  assign drain_ok  = !out_valid || out_ready;
  assign abort_hit = abort && (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign ks_seed   = seed_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (remaining != '0) ? RUN : DONE;
      RUN:     if ((remaining == '0) && drain_ok) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_comb begin
    busy     = (state != IDLE);
    in_ready = (state == RUN) && (remaining != '0) && drain_ok;
    ks_step  = in_valid && (state == RUN) && (remaining != '0) && drain_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_reg  <= SEED_DEFAULT;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      ks_load   <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      ks_load <= (state_nxt == LOAD);
      done    <= (state_nxt == DONE);
      if ((state == IDLE) && seed_shift && !start) begin
        seed_reg <= {seed_reg[SEED_W-2:0], seed_bit};
      end
      if (abort_hit) begin
        out_valid <= 1'b0;
        remaining <= '0;
      end else begin
        if (accept) begin
          out_valid <= 1'b1;
          out_bit   <= in_bit ^ ks_bit;
          remaining <= remaining - LEN_W'(1);
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        // Seed is kept across frames so each frame replays the same keystream.
        if ((state == IDLE) && start) begin
          remaining <= frame_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_cipher_seq.sv
// Bench for xor_cipher_seq: LFSR keystream environment, random frames, frame-level reference model.
module tb_xor_cipher_seq;
  localparam int SEED_W = 16;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              seed_bit, seed_shift, start, abort;
  logic [LEN_W-1:0]  frame_len;
  logic              in_valid = 1'b0, in_bit = 1'b0, in_ready;
  logic              out_valid, out_bit, out_ready = 1'b1;
  logic [SEED_W-1:0] ks_seed;
  logic              ks_load, ks_step, ks_bit;
  logic              busy, done;
  logic [LEN_W-1:0]  remaining;

  xor_cipher_seq #(.SEED_W(SEED_W), .SEED_DEFAULT(16'hACE1), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .seed_bit(seed_bit), .seed_shift(seed_shift), .start(start),
    .abort(abort), .frame_len(frame_len), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
    .ks_seed(ks_seed), .ks_load(ks_load), .ks_step(ks_step), .ks_bit(ks_bit),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // i-th keystream bit after loading seed
  function automatic logic ks_ref(input logic [15:0] seed, input int i);
    logic [15:0] s;
    s = seed;
    for (int k = 0; k < i; k++) s = lfsr_next(s);
    return s[0];
  endfunction

  logic [15:0] lfsr = 16'h0;
  logic        ks_force = 1'b0;
  always @(posedge clk) begin
    if (ks_load) lfsr <= ks_seed;
    else if (ks_step) lfsr <= lfsr_next(lfsr);
  end
  assign ks_bit = ks_force ? 1'b1 : lfsr[0];

  int          passes = 0, total = 0;
  int          cyc = 0, step_cnt = 0, load_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  logic [15:0] load_seed = 16'h0;
  logic [15:0] seed_model;
  logic        in_ready_seen = 1'b0;
  logic        outq[$];
  int          out_cyc[$];
  logic        src_bits[256];
  int          acc_cyc[256];
  int          src_idx = 0, src_n = 0, snk_mode = 0;
  logic        src_rand = 1'b0;

  // Source/sink drivers on the falling edge, monitor a few units later.
  always @(negedge clk) begin
    cyc++;
    case (snk_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 1) == 1);
      2:       out_ready = 1'b0;
      default: out_ready = (src_idx == 0);
    endcase
    if (src_idx < src_n) begin
      in_valid = src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bit   = src_bits[src_idx];
    end else begin
      in_valid = 1'b0;
      in_bit   = 1'b0;
    end
    #4;
    if (ks_step) step_cnt++;
    if (ks_load) begin load_cnt++; load_seed = ks_seed; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (in_ready) in_ready_seen = 1'b1;
    if (start && !busy) start_cyc = cyc;
    if (out_valid && out_ready) begin outq.push_back(out_bit); out_cyc.push_back(cyc); end
    if (in_valid && in_ready) begin acc_cyc[src_idx] = cyc; src_idx++; end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_frame(input int len, input int nsrc, input bit fill, input bit rnd);
    step_cnt = 0; load_cnt = 0; done_cnt = 0; in_ready_seen = 1'b0;
    outq.delete(); out_cyc.delete();
    if (fill) for (int i = 0; i < len; i++) src_bits[i] = ($urandom_range(0, 1) == 1);
    src_idx = 0; src_rand = rnd; src_n = nsrc;
    start = 1'b1; frame_len = LEN_W'(len);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    check("done_seen", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_frame(input int nout);
    logic e;
    check("load_cnt", 32'(load_cnt), 32'd1);
    check("load_seed", 32'(load_seed), 32'(seed_model));
    check("step_cnt", 32'(step_cnt), 32'(nout));
    check("out_cnt", 32'(outq.size()), 32'(nout));
    for (int i = 0; i < nout && i < outq.size(); i++) begin
      e = src_bits[i] ^ (ks_force ? 1'b1 : ks_ref(seed_model, i));
      check("out_bit", 32'(outq[i]), 32'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_bit"}, 32'(out_bit), 32'd0);
    check({tag, "_ks_load"}, 32'(ks_load), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_remaining"}, 32'(remaining), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_ks_step"}, 32'(ks_step), 32'd0);
    check({tag, "_ks_seed"}, 32'(ks_seed), 32'hACE1);
  endtask

  initial begin
    logic [15:0] val;
    logic        obit;
    int          n;
    seed_bit = 1'b0; seed_shift = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
    rst = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();
    seed_model = 16'hACE1;

    // Directed frame with a constant keystream of ones
    ks_force = 1'b1;
    src_bits[0] = 1'b1; src_bits[1] = 1'b0; src_bits[2] = 1'b1; src_bits[3] = 1'b1;
    run_frame(4, 4, 1'b0, 1'b0);
    wait_done(100);
    check_frame(4);
    for (int i = 0; i < 4 && i < out_cyc.size(); i++)
      check("latency", 32'(out_cyc[i]), 32'(acc_cyc[i] + 1));
    check("busy_after_frame", 32'(busy), 32'd0);
    ks_force = 1'b0;

    // Serial seed load, then start with a simultaneous shift that must be ignored
    val = 16'h1234;
    for (int i = 15; i >= 0; i--) begin seed_shift = 1'b1; seed_bit = val[i]; step(); end
    seed_shift = 1'b0;
    seed_model = 16'h1234;
    seed_shift = 1'b1; seed_bit = 1'b1; snk_mode = 1;
    run_frame(6, 6, 1'b1, 1'b1);
    seed_shift = 1'b0;
    wait_done(200);
    check_frame(6);

    // Backpressure after the first accept
    snk_mode = 3;
    run_frame(3, 3, 1'b1, 1'b0);
    repeat (4) step();
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_bit", 32'(out_bit), 32'(src_bits[0] ^ ks_ref(seed_model, 0)));
    check("bp_steps", 32'(step_cnt), 32'd1);
    check("bp_remaining", 32'(remaining), 32'd2);
    obit = out_bit;
    step();
    check("bp_hold", 32'(out_bit), 32'(obit));
    snk_mode = 0;
    wait_done(100);
    check_frame(3);
    if (out_cyc.size() > 0)
      check("done_after_last_out", 32'(done_cyc > out_cyc[out_cyc.size()-1]), 32'd1);

    // Empty frame
    run_frame(0, 0, 1'b0, 1'b0);
    wait_done(20);
    check_frame(0);
    check("len0_in_ready", 32'(in_ready_seen), 32'd0);
    check("len0_done_cyc", 32'(done_cyc), 32'(start_cyc + 2));

    // Abort after two of five bits
    run_frame(5, 2, 1'b1, 1'b0);
    n = 0;
    while (outq.size() < 2 && n < 50) begin step(); n++; end
    check("abort_outs", 32'(outq.size()), 32'd2);
    check("abort_rem_before", 32'(remaining), 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_remaining", 32'(remaining), 32'd0);
    step();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_steps", 32'(step_cnt), 32'd2);
    run_frame(3, 3, 1'b1, 1'b0);
    wait_done(100);
    check_frame(3);

    // Random frames with random valid/ready
    snk_mode = 1;
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 20);
      run_frame(n, n, 1'b1, 1'b1);
      wait_done(400);
      check_frame(n);
    end

    // Asynchronous reset in the middle of a frame
    run_frame(10, 10, 1'b1, 1'b1);
    repeat (4) step();
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    src_n = 0;
    step();
    rst = 1'b1;
    step();
    seed_model = 16'hACE1;
    snk_mode = 0;
    run_frame(2, 2, 1'b1, 1'b0);
    wait_done(50);
    check_frame(2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
